// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - request/result bundle between core and muldiv_sequencer
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Core side: issues operations, MTHI/MTLO and flushes; reads status and HI/LO.
    modport master (
        output start, op, a, b, flush, wr_hi, wr_lo, wdata,
        input  busy, done, div_zero, hi, lo
    );

    // Unit side.
    modport slave (
        input  start, op, a, b, flush, wr_hi, wr_lo, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative shift-add multiply / restoring divide with HI/LO pair
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_b,
    muldiv_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opnd;        // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0] acc;         // mult: {upper, multiplier}; div: {remainder, quotient}
    logic               res_neg;
    logic               rem_neg;
    logic               dz_q;        // divide by zero pending, resolves on first ITER edge
    logic               div_zero_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               idle_like;
    logic               accept;
    logic               in_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               b_zero;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand conditioning, one iteration step for each op, and the sign fix-up values.
    always_comb begin
        idle_like = (state == S_IDLE) || (state == S_DONE);
        accept    = bus.start && idle_like && !bus.flush;
        in_div    = bus.op[1];
        a_neg     = !bus.op[0] && bus.a[WIDTH-1];
        b_neg     = !bus.op[0] && bus.b[WIDTH-1];
        a_mag     = a_neg ? (~bus.a + 1'b1) : bus.a;
        b_mag     = b_neg ? (~bus.b + 1'b1) : bus.b;
        b_zero    = (bus.b == '0);

        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc[WIDTH-1:1]};

        // Remainder stays below the divisor, so the shifted value fits WIDTH+1 bits
        // and trial[WIDTH] is a clean borrow indicator.
        rem_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial     = rem_sh - {1'b0, opnd};
        if (!trial[WIDTH]) begin
            div_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end

        prod_fix  = res_neg ? (~acc + 1'b1) : acc;
        quo_fix   = res_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix   = rem_neg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    // Sequencer: IDLE/DONE accept, WIDTH iterations, one fix-up cycle, one done cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else if (bus.start) begin
                        state <= S_ITER;
                        count <= CW'(WIDTH);
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ITER: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                        count <= '0;
                    end else if (dz_q) begin
                        state <= S_DONE;
                        count <= '0;
                    end else begin
                        count <= count - 1'b1;
                        if (count == CW'(1)) begin
                            state <= S_FIX;
                        end
                    end
                end
                default: begin
                    state <= bus.flush ? S_IDLE : S_DONE;
                end
            endcase
        end
    end

    // Operand latch on accept and accumulator stepping during ITER.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            op_q    <= '0;
            opnd    <= '0;
            acc     <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            dz_q    <= 1'b0;
        end else if (accept) begin
            op_q    <= bus.op;
            res_neg <= a_neg ^ b_neg;
            rem_neg <= in_div && a_neg;
            dz_q    <= in_div && b_zero;
            opnd    <= in_div ? b_mag : a_mag;
            // Divide by zero keeps the raw dividend so HI can return it untouched.
            if (in_div) begin
                acc <= {{WIDTH{1'b0}}, (b_zero ? bus.a : a_mag)};
            end else begin
                acc <= {{WIDTH{1'b0}}, b_mag};
            end
        end else if (state == S_ITER && !dz_q) begin
            acc <= op_q[1] ? div_next : mul_next;
        end
    end

    // HI/LO and div_zero: results on FIX or divide-by-zero, MTHI/MTLO only when not busy.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else if (state == S_FIX) begin
            if (!bus.flush) begin
                if (op_q[1]) begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end else begin
                    {hi_q, lo_q} <= prod_fix;
                end
            end
        end else if (state == S_ITER) begin
            if (dz_q && !bus.flush) begin
                hi_q       <= acc[WIDTH-1:0];
                lo_q       <= '1;
                div_zero_q <= 1'b1;
            end
        end else begin
            if (bus.wr_hi) begin
                hi_q <= bus.wdata;
            end
            if (bus.wr_lo) begin
                lo_q <= bus.wdata;
            end
            if (accept) begin
                div_zero_q <= 1'b0;
            end
        end
    end

    assign bus.busy     = (state == S_ITER) || (state == S_FIX);
    assign bus.done     = (state == S_DONE);
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
